// File: rtl/hazard_control_unit_if.sv
// Pipeline-register fields into the hazard controller and the stall/flush/forward controls out.
interface hazard_control_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       rs_id_i;
    logic [4:0]       rt_id_i;
    logic             uses_rs_id_i;
    logic             uses_rt_id_i;
    logic             r_enable_ex_i;
    logic             reg_write_ex_i;
    logic [4:0]       reg_dest_ex_i;
    logic             reg_write_mem_i;
    logic [4:0]       reg_dest_mem_i;
    logic             reg_write_wb_i;
    logic [4:0]       reg_dest_wb_i;
    logic [4:0]       rs_ex_i;
    logic [4:0]       rt_ex_i;
    logic             pcsel_mem_i;

    logic             stall_pc_o;
    logic             stall_ifid_o;
    logic             bubble_idex_o;
    logic             flush_ifid_o;
    logic             flush_idex_o;
    logic             flush_exmem_o;
    logic [1:0]       forward_a_o;
    logic [1:0]       forward_b_o;
    logic [CNT_W-1:0] stall_count_o;
    logic [CNT_W-1:0] flush_count_o;

    modport master (
        output rs_id_i, rt_id_i, uses_rs_id_i, uses_rt_id_i,
        output r_enable_ex_i, reg_write_ex_i, reg_dest_ex_i,
        output reg_write_mem_i, reg_dest_mem_i, reg_write_wb_i, reg_dest_wb_i,
        output rs_ex_i, rt_ex_i, pcsel_mem_i,
        input  stall_pc_o, stall_ifid_o, bubble_idex_o,
        input  flush_ifid_o, flush_idex_o, flush_exmem_o,
        input  forward_a_o, forward_b_o, stall_count_o, flush_count_o
    );

    modport slave (
        input  rs_id_i, rt_id_i, uses_rs_id_i, uses_rt_id_i,
        input  r_enable_ex_i, reg_write_ex_i, reg_dest_ex_i,
        input  reg_write_mem_i, reg_dest_mem_i, reg_write_wb_i, reg_dest_wb_i,
        input  rs_ex_i, rt_ex_i, pcsel_mem_i,
        output stall_pc_o, stall_ifid_o, bubble_idex_o,
        output flush_ifid_o, flush_idex_o, flush_exmem_o,
        output forward_a_o, forward_b_o, stall_count_o, flush_count_o
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage MIPS core: RAW stalls, redirect flush FSM, event counters.
// Define FORWARDING_EN to stall only on load-use and drive the EX operand forwarding selects.
module hazard_control_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input logic                  clk,
    input logic                  rst,
    hazard_control_unit_if.slave hz
);
    localparam int unsigned       FCNT_W    = 3;
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e            state_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              flush_entry;
    logic              in_flush;
    logic              flushing;
    logic              hazard;
    logic              stall;

    function automatic logic raw_hit(input logic [4:0] src, input logic uses,
                                     input logic we, input logic [4:0] dst);
        return uses && (src != 5'd0) && we && (dst == src);
    endfunction

`ifdef FORWARDING_EN
    // EX/MEM result is younger than WB data, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic we_mem, input logic [4:0] dst_mem,
                                           input logic we_wb,  input logic [4:0] dst_wb);
        if (src == 5'd0)                      return 2'b00;
        else if (we_mem && (dst_mem == src))  return 2'b10;
        else if (we_wb && (dst_wb == src))    return 2'b01;
        else                                  return 2'b00;
    endfunction
`endif

    always_comb begin
        flush_entry = (state_q == ST_RUN) && hz.pcsel_mem_i;
        in_flush    = (state_q == ST_FLUSH);
        flushing    = flush_entry || in_flush;
`ifdef FORWARDING_EN
        hazard = hz.r_enable_ex_i &&
                 (raw_hit(hz.rs_id_i, hz.uses_rs_id_i, hz.reg_write_ex_i, hz.reg_dest_ex_i) ||
                  raw_hit(hz.rt_id_i, hz.uses_rt_id_i, hz.reg_write_ex_i, hz.reg_dest_ex_i));
`else
        // WB is written before ID reads the regfile, so only EX and MEM producers matter.
        hazard = raw_hit(hz.rs_id_i, hz.uses_rs_id_i, hz.reg_write_ex_i,  hz.reg_dest_ex_i)  ||
                 raw_hit(hz.rt_id_i, hz.uses_rt_id_i, hz.reg_write_ex_i,  hz.reg_dest_ex_i)  ||
                 raw_hit(hz.rs_id_i, hz.uses_rs_id_i, hz.reg_write_mem_i, hz.reg_dest_mem_i) ||
                 raw_hit(hz.rt_id_i, hz.uses_rt_id_i, hz.reg_write_mem_i, hz.reg_dest_mem_i);
`endif
        stall = hazard && !flushing;
    end

    assign hz.stall_pc_o    = stall;
    assign hz.stall_ifid_o  = stall;
    assign hz.bubble_idex_o = stall;
    assign hz.flush_ifid_o  = flushing;
    assign hz.flush_idex_o  = flush_entry;
    assign hz.flush_exmem_o = flush_entry;

`ifdef FORWARDING_EN
    assign hz.forward_a_o = fwd_sel(hz.rs_ex_i, hz.reg_write_mem_i, hz.reg_dest_mem_i,
                                    hz.reg_write_wb_i, hz.reg_dest_wb_i);
    assign hz.forward_b_o = fwd_sel(hz.rt_ex_i, hz.reg_write_mem_i, hz.reg_dest_mem_i,
                                    hz.reg_write_wb_i, hz.reg_dest_wb_i);
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{hz.rs_ex_i, hz.rt_ex_i, hz.reg_write_wb_i,
                                 hz.reg_dest_wb_i, hz.r_enable_ex_i};
    assign hz.forward_a_o = 2'b00;
    assign hz.forward_b_o = 2'b00;
`endif

    // Redirect FSM; the entry cycle is RUN with PCSel_MEM, FLUSH covers the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hz.pcsel_mem_i) begin
                        state_q <= ST_FLUSH;
                        fcnt_q  <= FCNT_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_q <= FCNT_W'(1)) begin
                        state_q <= ST_RUN;
                        fcnt_q  <= '0;
                    end else begin
                        fcnt_q <= fcnt_q - FCNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1))       stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_entry && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_count_o = stall_cnt_q;
    assign hz.flush_count_o = flush_cnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed vectors plus a per-cycle reference model.
module tb_hazard_control_unit;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned CNT_W        = 16;
    localparam int          MAXC         = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_left   = 0;
    int   m_stall  = 0;
    int   m_flush  = 0;

    hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_control_unit #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    always #5 clk = ~clk;

    wire [9:0]  ctl  = {bus.stall_pc_o, bus.stall_ifid_o, bus.bubble_idex_o,
                        bus.flush_ifid_o, bus.flush_idex_o, bus.flush_exmem_o,
                        bus.forward_a_o, bus.forward_b_o};
    wire [31:0] cnts = {bus.stall_count_o, bus.flush_count_o};
    wire [2:0]  fl3  = {bus.flush_ifid_o, bus.flush_idex_o, bus.flush_exmem_o};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference rules: which producers can block an ID read, and where EX operands come from.
    function automatic bit model_hazard();
        logic [4:0] src [2];
        bit         rd  [2];
        src[0] = bus.rs_id_i;      src[1] = bus.rt_id_i;
        rd[0]  = bus.uses_rs_id_i; rd[1]  = bus.uses_rt_id_i;
        for (int i = 0; i < 2; i++) begin
            if (rd[i] && src[i] != 5'd0) begin
`ifdef FORWARDING_EN
                if (bus.r_enable_ex_i && bus.reg_write_ex_i && bus.reg_dest_ex_i == src[i]) return 1'b1;
`else
                if (bus.reg_write_ex_i && bus.reg_dest_ex_i == src[i]) return 1'b1;
                if (bus.reg_write_mem_i && bus.reg_dest_mem_i == src[i]) return 1'b1;
`endif
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
`ifdef FORWARDING_EN
        if (bus.reg_write_mem_i && bus.reg_dest_mem_i == src) return 2'b10;
        if (bus.reg_write_wb_i && bus.reg_dest_wb_i == src) return 2'b01;
`endif
        return 2'b00;
    endfunction

    // Per-cycle compare; inputs are stable from posedge+1, so the model advances here too.
    always @(negedge clk) begin
        bit         entry, fl, st;
        logic [9:0] exp_ctl;
        if (rst) begin
            m_left = 0; m_stall = 0; m_flush = 0;
        end
        entry   = (m_left == 0) && bus.pcsel_mem_i;
        fl      = entry || (m_left > 0);
        st      = model_hazard() && !fl;
        exp_ctl = {st, st, st, fl, entry, entry, model_fwd(bus.rs_ex_i), model_fwd(bus.rt_ex_i)};
        check("cycle_ctl", 32'(ctl), 32'(exp_ctl));
        check("cycle_cnt", cnts, {16'(m_stall), 16'(m_flush)});
        if (!rst) begin
            if (st && m_stall < MAXC) m_stall++;
            if (entry) begin
                m_left = (FLUSH_CYCLES > 1) ? int'(FLUSH_CYCLES) - 1 : 1;
                if (m_flush < MAXC) m_flush++;
            end else if (m_left > 0) begin
                m_left--;
            end
        end
    end

    task automatic idle();
        bus.rs_id_i = '0; bus.rt_id_i = '0; bus.uses_rs_id_i = 1'b0; bus.uses_rt_id_i = 1'b0;
        bus.r_enable_ex_i = 1'b0; bus.reg_write_ex_i = 1'b0; bus.reg_dest_ex_i = '0;
        bus.reg_write_mem_i = 1'b0; bus.reg_dest_mem_i = '0;
        bus.reg_write_wb_i = 1'b0; bus.reg_dest_wb_i = '0;
        bus.rs_ex_i = '0; bus.rt_ex_i = '0; bus.pcsel_mem_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_ctl", 32'(ctl), 32'h0);
        check("reset_cnt", cnts, 32'h0);

        // add $3 in EX, ID reads $3; the add then moves to MEM and WB
        next_cycle();
        bus.reg_write_ex_i = 1'b1; bus.reg_dest_ex_i = 5'd3; bus.rs_id_i = 5'd3; bus.uses_rs_id_i = 1'b1;
        #1;
`ifdef FORWARDING_EN
        check("add_ex_nostall", 32'(bus.stall_pc_o), 32'h0);
`else
        check("add_ex_stall", 32'(bus.stall_pc_o), 32'h1);
`endif
        next_cycle();
        bus.reg_write_mem_i = 1'b1; bus.reg_dest_mem_i = 5'd3; bus.rs_id_i = 5'd3; bus.uses_rs_id_i = 1'b1;
        #1;
`ifdef FORWARDING_EN
        check("add_mem_bubble", 32'(bus.bubble_idex_o), 32'h0);
`else
        check("add_mem_bubble", 32'(bus.bubble_idex_o), 32'h1);
`endif
        next_cycle();
        bus.reg_write_wb_i = 1'b1; bus.reg_dest_wb_i = 5'd3; bus.rs_id_i = 5'd3; bus.uses_rs_id_i = 1'b1;
        #1;
        check("add_wb_release", 32'(bus.stall_pc_o), 32'h0);
`ifdef FORWARDING_EN
        check("add_stall_count", 32'(bus.stall_count_o), 32'h0);
`else
        check("add_stall_count", 32'(bus.stall_count_o), 32'h2);
`endif

        // lw $5 in EX, ID reads rt=$5
        next_cycle();
        bus.r_enable_ex_i = 1'b1; bus.reg_write_ex_i = 1'b1; bus.reg_dest_ex_i = 5'd5;
        bus.rt_id_i = 5'd5; bus.uses_rt_id_i = 1'b1;
        #1;
        check("lw_stall", 32'(bus.stall_pc_o), 32'h1);
        next_cycle();
        bus.reg_write_mem_i = 1'b1; bus.reg_dest_mem_i = 5'd5; bus.rt_id_i = 5'd5; bus.uses_rt_id_i = 1'b1;
        #1;
`ifdef FORWARDING_EN
        check("lw_one_cycle", 32'(bus.stall_pc_o), 32'h0);
`else
        check("lw_mem_stall", 32'(bus.stall_pc_o), 32'h1);
`endif
        next_cycle();
        bus.reg_write_wb_i = 1'b1; bus.reg_dest_wb_i = 5'd5; bus.rt_ex_i = 5'd5;
        #1;
`ifdef FORWARDING_EN
        check("lw_fwd_b_wb", 32'(bus.forward_b_o), 32'h1);
`else
        check("lw_fwd_b_tied", 32'(bus.forward_b_o), 32'h0);
`endif

        // EX/MEM and WB both write $7; then writes to $0 with rs_EX=$0
        next_cycle();
        bus.reg_write_mem_i = 1'b1; bus.reg_dest_mem_i = 5'd7;
        bus.reg_write_wb_i = 1'b1; bus.reg_dest_wb_i = 5'd7; bus.rs_ex_i = 5'd7;
        #1;
`ifdef FORWARDING_EN
        check("fwd_a_priority", 32'(bus.forward_a_o), 32'h2);
`else
        check("fwd_a_tied", 32'(bus.forward_a_o), 32'h0);
`endif
        next_cycle();
        bus.reg_write_mem_i = 1'b1; bus.reg_write_wb_i = 1'b1;
        #1;
        check("fwd_a_zero_reg", 32'(bus.forward_a_o), 32'h0);

        // redirect together with a load-use hazard; second PCSel_MEM lands in FLUSH
        next_cycle();
        bus.pcsel_mem_i = 1'b1; bus.r_enable_ex_i = 1'b1; bus.reg_write_ex_i = 1'b1;
        bus.reg_dest_ex_i = 5'd5; bus.rs_id_i = 5'd5; bus.uses_rs_id_i = 1'b1;
        #1;
        check("redir_entry_flush", 32'(fl3), 32'h7);
        check("redir_entry_nostall", 32'(bus.stall_pc_o), 32'h0);
        next_cycle();
        bus.pcsel_mem_i = 1'b1; bus.r_enable_ex_i = 1'b1; bus.reg_write_ex_i = 1'b1;
        bus.reg_dest_ex_i = 5'd5; bus.rs_id_i = 5'd5; bus.uses_rs_id_i = 1'b1;
        #1;
        check("redir_flush_ifid_only", 32'(fl3), 32'h4);
        check("redir_flush_nostall", 32'(bus.stall_pc_o), 32'h0);
        check("redir_flush_count", 32'(bus.flush_count_o), 32'h1);
        next_cycle();
        #1;
        check("redir_back_run", 32'(fl3), 32'h0);
        check("redir_ignored_count", 32'(bus.flush_count_o), 32'h1);

        // asynchronous reset while in FLUSH
        next_cycle();
        bus.pcsel_mem_i = 1'b1;
        next_cycle();
        #1;
        check("mid_flush_ifid", 32'(bus.flush_ifid_o), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_ctl", 32'(ctl), 32'h0);
        check("async_rst_cnt", cnts, 32'h0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("post_rst_run", 32'(ctl), 32'h0);

        // saturate StallCount with a held hazard
        next_cycle();
        bus.r_enable_ex_i = 1'b1; bus.reg_write_ex_i = 1'b1; bus.reg_dest_ex_i = 5'd3;
        bus.rs_id_i = 5'd3; bus.uses_rs_id_i = 1'b1;
        repeat (16'hFFFE) @(posedge clk);
        #2;
        check("stall_cnt_fffe", 32'(bus.stall_count_o), 32'hFFFE);
        repeat (3) @(posedge clk);
        #2;
        check("stall_cnt_sat", 32'(bus.stall_count_o), 32'hFFFF);
        check("stall_still_on", 32'(bus.stall_pc_o), 32'h1);

        next_cycle();
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
